// File: rtl/my_mux8way_rr_pkg.sv
// ---------------------------------------------------------------------------
// my_mux8way_rr_pkg
// Shared constants for the 8-way gather/scatter family (dmux8way, RAM8,
// my_mux8way_rr) plus a small one-hot helper.
//   NCH        : number of source channels
//   SELW       : width of a channel index
//   DEF_WIDTH  : default data word width
//   PTR_RESET  : last-grant pointer value after reset (channel 0 goes first)
// ---------------------------------------------------------------------------
package my_mux8way_rr_pkg;

  localparam int NCH       = 8;
  localparam int SELW      = 3;
  localparam int DEF_WIDTH = 16;

  localparam logic [SELW-1:0] PTR_RESET = 3'd7;

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] onehot8(input logic [SELW-1:0] idx);
    logic [NCH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/my_mux8way_rr_pick8.sv
// ---------------------------------------------------------------------------
// my_rr_pick8
// Combinational round-robin picker. Finds the first set bit of req searching
// from ptr+1 upward, wrapping 7 -> 0.
//   req [7:0] : request vector
//   ptr [2:0] : last granted channel
//   g   [2:0] : granted channel (valid only when hit=1, 0 otherwise)
//   hit       : at least one request bit is set
// Method: rotate req right by ptr+1 so the highest-priority candidate lands
// in bit 0, fixed-priority encode, then add ptr+1 back (mod 8).
// ---------------------------------------------------------------------------
module my_rr_pick8
  import my_mux8way_rr_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] g,
  output logic            hit
);

  logic [SELW-1:0]  base;
  logic [2*NCH-1:0] dbl;
  logic [2*NCH-1:0] shifted;
  logic [NCH-1:0]   rot;
  logic [SELW-1:0]  idx;

  // 3-bit add wraps naturally, so ptr=7 gives base=0.
  assign base    = ptr + 3'd1;
  assign dbl     = {req, req};
  assign shifted = dbl >> base;
  assign rot     = shifted[NCH-1:0];

  // Lowest set bit of the rotated vector wins; scan high to low so the last
  // write is the lowest index.
  always_comb begin
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) idx = SELW'(i);
    end
  end

  assign hit = |req;
  assign g   = hit ? (idx + base) : '0;

endmodule

// File: rtl/my_mux8way_rr.sv
// ---------------------------------------------------------------------------
// my_mux8way_rr
// 8-to-1 round-robin gather. Accepts one word per cycle from eight
// valid/ready source channels and forwards it on a single registered output,
// tagged with the index of the source channel.
//   clk                  : clock, rising edge
//   reset                : synchronous active-high reset
//   in_valid  [7:0]      : per-channel request
//   in_ready  [7:0]      : per-channel accept, at most one bit set
//   in_data   [8*WIDTH]  : channel i word at [i*WIDTH +: WIDTH]
//   out_valid            : output register holds a word
//   out_ready            : downstream accepts the word this cycle
//   out_data  [WIDTH]    : forwarded word (registered)
//   out_sel   [2:0]      : source channel of out_data (registered)
// ---------------------------------------------------------------------------
module my_mux8way_rr
  import my_mux8way_rr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  logic                vld_p0;
  logic [WIDTH-1:0]    data_p0;
  logic [SELW-1:0]     sel_p0;
  logic [SELW-1:0]     ptr;

  logic                free;
  logic                take;
  logic                hit;
  logic [SELW-1:0]     g;
  logic [WIDTH-1:0]    g_data;

  // The output slot can be refilled when empty or when it drains this
  // cycle, which gives full throughput without a bubble.
  assign free = !vld_p0 || out_ready;

  my_rr_pick8 u_pick (
    .req (in_valid),
    .ptr (ptr),
    .g   (g),
    .hit (hit)
  );

  assign take     = free && hit && !reset;
  assign in_ready = take ? onehot8(g) : '0;

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g == SELW'(i)) g_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // ---- source handshake -> output register (p0) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
      ptr     <= PTR_RESET;
    end else if (free) begin
      if (hit) begin
        vld_p0  <= 1'b1;
        data_p0 <= g_data;
        sel_p0  <= g;
        ptr     <= g;
      end else begin
        // Nothing to forward: slot empties; data, tag and pointer hold.
        vld_p0  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_sel   = sel_p0;

endmodule

// File: tb/tb_my_mux8way_rr.sv
// ---------------------------------------------------------------------------
// tb_my_mux8way_rr
// Directed scenarios followed by random traffic, every cycle compared
// against a cycle-level reference model of the gather behaviour.
// ---------------------------------------------------------------------------
module tb_my_mux8way_rr;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     in_valid;
  logic [7:0]     in_ready;
  logic [8*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit        m_valid;
  bit [15:0] m_data;
  int        m_sel;
  int        m_ptr;

  always #5 clk = ~clk;

  my_mux8way_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which channel the rules select now, or -1 if none / slot busy / reset.
  function automatic int model_grant();
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 1; k <= 8; k++) begin
      int ch;
      ch = (m_ptr + k) % 8;
      if (in_valid[ch]) return ch;
    end
    return -1;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then return 1 time unit later so the caller can change inputs.
  task automatic cyc();
    int gr;
    logic [7:0] exp_rdy;
    @(negedge clk);
    gr = model_grant();
    exp_rdy = 8'h00;
    if (gr >= 0) exp_rdy[gr] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_sel", out_sel, m_sel);
    end
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 7;
    end else if (!m_valid || out_ready) begin
      if (gr >= 0) begin
        m_valid = 1; m_data = in_data[gr*16 +: 16]; m_sel = gr; m_ptr = gr;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] v);
    in_data[ch*16 +: 16] = v;
  endtask

  initial begin
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 7;
    reset = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) set_ch(i, 16'($urandom));

    // Reset with all channels requesting
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_out_sel", out_sel, 3'd0);
    chk("rst_in_ready", in_ready, 8'h00);

    // Release, idle
    reset = 1'b0; in_valid = 8'h00; in_data = '0; out_ready = 1'b0;
    cyc(); cyc();
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_out_data", out_data, 16'h0);

    // Single channel
    in_valid = 8'h20; set_ch(5, 16'hBEEF); out_ready = 1'b1;
    #1;
    chk("single_in_ready", in_ready, 8'h20);
    cyc();
    in_valid = 8'h00;
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 16'hBEEF);
    chk("single_sel", out_sel, 3'd5);

    // Round-robin from a fresh reset
    reset = 1'b1; cyc(); reset = 1'b0;
    in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) set_ch(i, 16'h1000 + 16'(i));
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("rr_valid", out_valid, 1'b1);
      chk("rr_sel", out_sel, 32'(i % 8));
      chk("rr_data", out_data, 32'h1000 + 32'(i % 8));
    end

    // Backpressure: ch2 and ch6
    in_valid = 8'h44; set_ch(2, 16'h2222); set_ch(6, 16'h6666);
    cyc();
    chk("bp_first_sel", out_sel, 3'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_stall_ready", in_ready, 8'h00);
      cyc();
      chk("bp_hold_sel", out_sel, 3'd2);
      chk("bp_hold_data", out_data, 16'h2222);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_refill_ready", in_ready, 8'h40);
    cyc();
    chk("bp_refill_sel", out_sel, 3'd6);
    chk("bp_refill_valid", out_valid, 1'b1);
    cyc();
    chk("bp_again_sel", out_sel, 3'd2);

    // Wrap: grant ch7, then 0 beats 7
    in_valid = 8'h80; set_ch(7, 16'h7777); set_ch(0, 16'h0A0A);
    cyc();
    chk("wrap_sel7", out_sel, 3'd7);
    in_valid = 8'h81;
    cyc();
    chk("wrap_sel0", out_sel, 3'd0);
    cyc();
    chk("wrap_sel7b", out_sel, 3'd7);

    // Skip: ch3 requests during a stall, then withdraws before grant
    out_ready = 1'b0; in_valid = 8'h08; set_ch(3, 16'h3333);
    cyc();
    in_valid = 8'h00; out_ready = 1'b1;
    cyc();
    chk("skip_valid_low", out_valid, 1'b0);
    chk("skip_hold_sel", out_sel, 3'd7);
    in_valid = 8'hFF;
    cyc();
    chk("skip_ptr_kept", out_sel, 3'd0);

    // Mid-stream reset while holding ch4
    in_valid = 8'h10; set_ch(4, 16'h4444);
    cyc();
    chk("mid_sel4", out_sel, 3'd4);
    in_valid = 8'h00; out_ready = 1'b0; reset = 1'b1;
    in_valid = 8'hFF;
    #1;
    chk("mid_rst_ready", in_ready, 8'h00);
    cyc();
    chk("mid_rst_valid", out_valid, 1'b0);
    reset = 1'b0; out_ready = 1'b1;
    cyc();
    chk("mid_after_sel", out_sel, 3'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) set_ch(i, 16'($urandom));
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
